bram_load_port: RTL and testbench



---
 rtl/mem_port_pkg.sv | 27 ++
 rtl/load_resp_fifo.sv | 51 +++++
 rtl/bram_load_port.sv | 63 ++++++
 tb/tb_bram_load_port.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared helpers for the memory-port front ends: ceil-log2 and the
// pointer/occupancy widths derived from a FIFO depth.
package mem_port_pkg;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return result;
   endfunction

   // Occupancy must represent 0..depth inclusive.
   function automatic int occ_width(input int depth);
      return clog2(depth + 1);
   endfunction

   // A depth-1 FIFO still gets a 1-bit pointer that simply never moves.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/load_resp_fifo.sv
// Response FIFO: synchronous write, combinational read of the head entry,
// occupancy exported for the credit check in the load port.
module load_resp_fifo
   import mem_port_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [DATA_WIDTH-1:0]         push_data,
   input  logic                          pop,
   output logic [DATA_WIDTH-1:0]         pop_data,
   output logic [occ_width(DEPTH)-1:0]   occ
);

   localparam int PTR_W = ptr_width(DEPTH);
   localparam int OCC_W = occ_width(DEPTH);

   logic [DATA_WIDTH-1:0] storage [DEPTH];
   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            storage[i] <= '0;
         end
      end else begin
         if (push) begin
            storage[tail] <= push_data;
            tail          <= next_ptr(tail);
         end
         if (pop) begin
            head <= next_ptr(head);
         end
         occ <= occ + OCC_W'(push) - OCC_W'(pop);
      end
   end

   assign pop_data = storage[head];

endmodule

// File: rtl/bram_load_port.sv
// Load-side elastic front end: credit-checked issue of BRAM reads and a
// response FIFO that turns the fixed one-cycle read into a valid/ready stream.
module bram_load_port
   import mem_port_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic                  addr_in_valid,
   output logic                  addr_in_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_out_valid,
   input  logic                  data_out_ready,
   output logic                  loadEn,
   output logic [ADDR_WIDTH-1:0] loadAddr,
   input  logic [DATA_WIDTH-1:0] loadData
);

   localparam int OCC_W = occ_width(DEPTH);
   localparam int CW    = OCC_W + 1;

   logic             inflight;
   logic             pop;
   logic [OCC_W-1:0] occ;
   logic [CW-1:0]    credits_used;

   assign data_out_valid = (occ != '0);
   assign pop            = data_out_valid && data_out_ready;

   // Every issued read must find a free slot when it returns, counting the
   // slot freed by a pop in this same cycle.
   assign credits_used  = CW'(occ) + CW'(inflight) - CW'(pop);
   assign addr_in_ready = credits_used < CW'(DEPTH);

   assign loadEn   = rst && addr_in_valid && addr_in_ready;
   assign loadAddr = addr_in;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight <= 1'b0;
      end else begin
         inflight <= loadEn;
      end
   end

   load_resp_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data (loadData),
      .pop       (pop),
      .pop_data  (data_out),
      .occ       (occ)
   );

endmodule

// File: tb/tb_bram_load_port.sv
// Self-checking bench for bram_load_port: a BRAM model with one-cycle read
// latency and a queue-based reference of accepted-but-undelivered loads.
module tb_bram_load_port;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 4;

   logic          clk;
   logic          rst;
   logic [AW-1:0] addr_in;
   logic          addr_in_valid;
   logic          addr_in_ready;
   logic [DW-1:0] data_out;
   logic          data_out_valid;
   logic          data_out_ready;
   logic          loadEn;
   logic [AW-1:0] loadAddr;
   logic [DW-1:0] loadData;

   bram_load_port #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .addr_in        (addr_in),
      .addr_in_valid  (addr_in_valid),
      .addr_in_ready  (addr_in_ready),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready),
      .loadEn         (loadEn),
      .loadAddr       (loadAddr),
      .loadData       (loadData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM model: data appears one cycle after loadEn, garbage otherwise.
   logic [DW-1:0] mem [16];
   always @(posedge clk) begin
      if (loadEn) loadData <= mem[loadAddr];
      else        loadData <= DW'($urandom);
   end

   typedef struct {
      logic [DW-1:0] data;
      int            ready_cycle;
   } exp_t;

   exp_t q[$];
   int   cycle       = 0;
   int   checkCount  = 0;
   int   errorCount  = 0;
   int   acceptCount = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                  tag, observed, expected, cycle);
      end
   endtask

   // Drive one cycle of inputs, then compare the DUT against the reference
   // at the negative edge and advance the reference past the next rising edge.
   task automatic applyStimulus(input logic rv, input logic v,
                                input logic [AW-1:0] a, input logic r);
      logic exp_valid;
      logic exp_pop;
      logic exp_ready;
      logic exp_en;
      @(posedge clk);
      #1;
      rst            = rv;
      addr_in_valid  = v;
      addr_in        = a;
      data_out_ready = r;
      @(negedge clk);
      if (!rst) q.delete();
      exp_valid = (q.size() > 0) && (q[0].ready_cycle <= cycle);
      exp_pop   = exp_valid && data_out_ready;
      exp_ready = (q.size() - int'(exp_pop)) < DEPTH;
      exp_en    = rst && addr_in_valid && exp_ready;
      checkOutput("addr_in_ready", addr_in_ready, exp_ready);
      checkOutput("loadEn", loadEn, exp_en);
      checkOutput("data_out_valid", data_out_valid, exp_valid);
      if (exp_valid) checkOutput("data_out", data_out, q[0].data);
      if (exp_en) checkOutput("loadAddr", loadAddr, addr_in);
      checkOutput("occ_le_depth", 32'(int'(dut.u_fifo.occ) <= DEPTH), 1);
      if (exp_pop) void'(q.pop_front());
      if (exp_en) begin
         q.push_back('{data: mem[addr_in], ready_cycle: cycle + 2});
         acceptCount++;
      end
      cycle++;
   endtask

   initial begin
      rst            = 1'b0;
      addr_in_valid  = 1'b1;
      addr_in        = '0;
      data_out_ready = 1'b0;
      loadData       = '0;
      for (int i = 0; i < 16; i++) mem[i] = DW'(i + 'h10);

      // Reset held with a valid address pending
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 4'd7, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
      checkOutput("reset_data_out", data_out, 0);

      // Single load
      mem[5] = 8'h3C;
      applyStimulus(1'b1, 1'b1, 4'd5, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1);
      checkOutput("single_data", data_out, 8'h3C);
      checkOutput("single_valid", data_out_valid, 1);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
      checkOutput("single_empty", data_out_valid, 0);

      // Streaming
      for (int i = 0; i < 16; i++) mem[i] = DW'(i + 'h10);
      acceptCount = 0;
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, AW'(i), 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'd0, 1'b1);
      checkOutput("stream_accepted", acceptCount, 16);
      checkOutput("stream_drained", q.size(), 0);

      // Back-pressure
      acceptCount = 0;
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, AW'(i + 2), 1'b0);
      checkOutput("bp_accepted", acceptCount, DEPTH);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, AW'(i + 10), 1'b1);
      for (int i = 0; i < 8 && q.size() > 0; i++) applyStimulus(1'b1, 1'b0, 4'd0, 1'b1);
      checkOutput("bp_drained", q.size(), 0);

      // Reset mid-flight
      mem[3] = 8'hA5;
      applyStimulus(1'b1, 1'b1, 4'd3, 1'b1);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 4'd0, 1'b1);
      checkOutput("midreset_occ", 32'(dut.u_fifo.occ), 0);

      // Random traffic
      for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
      acceptCount = 0;
      for (int c = 0; c < 5000 && acceptCount < 200; c++) begin
         applyStimulus(1'b1, $urandom_range(0, 99) < 70, AW'($urandom),
                       $urandom_range(0, 99) < 60);
      end
      checkOutput("rand_accepted", acceptCount, 200);
      for (int c = 0; c < 20 && q.size() > 0; c++) applyStimulus(1'b1, 1'b0, 4'd0, 1'b1);
      checkOutput("rand_drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
